// File: rtl/vga_pkg.sv
// Shared VGA constants: 640x480@60 Hz raster timing, count width and the
// colour palette used by board_controller. Visible window is
// hCount 144..783, vCount 35..514; every downstream coordinate uses this frame.
package vga_pkg;

    // Width of hCount / vCount.
    localparam int COUNT_W = 10;

    // Board clocks per pixel (100 MHz -> 25 MHz).
    localparam int CLK_DIV = 4;

    // Horizontal timing, in pixels.
    localparam int H_TOTAL = 800;
    localparam int H_SYNC  = 96;
    localparam int H_START = 144;
    localparam int H_END   = 783;

    // Vertical timing, in lines.
    localparam int V_TOTAL = 525;
    localparam int V_SYNC  = 2;
    localparam int V_START = 35;
    localparam int V_END   = 514;

    typedef logic [COUNT_W-1:0] count_t;

    // 12-bit RGB (4:4:4) colours shared with board_controller.
    localparam logic [11:0] COLOR_BLACK = 12'h000;
    localparam logic [11:0] COLOR_WHITE = 12'hFFF;
    localparam logic [11:0] COLOR_RED   = 12'hF00;
    localparam logic [11:0] COLOR_GREEN = 12'h0F0;
    localparam logic [11:0] COLOR_BLUE  = 12'h00F;

endpackage

// File: rtl/mod_counter.sv
// Modulo-N up counter with enable. count_next exposes the value the counter
// takes on the coming edge so callers can decode registered outputs with no
// skew against the count itself. wrap is high when an enabled step rolls
// N-1 over to 0.
module mod_counter #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] count,
    output logic [W-1:0] count_next,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    // Next-state and wrap decode.
    always_comb begin
        wrap       = en && (count == LAST);
        count_next = count;
        if (en) begin
            count_next = wrap ? '0 : count + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator. A divider produces pix_en once every CLK_DIV
// clocks; on the following edge the horizontal counter steps and, at the end
// of a line, the vertical counter steps. hSync/vSync/bright are registered
// from the next-state counts so they change on the same edge as the counts.
// Optional feature macro: VGA_FRAME_TICK_EN (frame_tick pulse at the start of
// vertical blanking; tied low when undefined).
module vga_timing_gen #(
    parameter int CLK_DIV = vga_pkg::CLK_DIV,
    parameter int H_TOTAL = vga_pkg::H_TOTAL,
    parameter int H_SYNC  = vga_pkg::H_SYNC,
    parameter int H_START = vga_pkg::H_START,
    parameter int H_END   = vga_pkg::H_END,
    parameter int V_TOTAL = vga_pkg::V_TOTAL,
    parameter int V_SYNC  = vga_pkg::V_SYNC,
    parameter int V_START = vga_pkg::V_START,
    parameter int V_END   = vga_pkg::V_END
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic                         pix_en,
    output logic [vga_pkg::COUNT_W-1:0]  hCount,
    output logic [vga_pkg::COUNT_W-1:0]  vCount,
    output logic                         hSync,
    output logic                         vSync,
    output logic                         bright,
    output logic                         frame_tick
);

    localparam int CW    = vga_pkg::COUNT_W;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CW-1:0]    H_SYNC_C  = CW'(H_SYNC);
    localparam logic [CW-1:0]    H_START_C = CW'(H_START);
    localparam logic [CW-1:0]    H_END_C   = CW'(H_END);
    localparam logic [CW-1:0]    V_SYNC_C  = CW'(V_SYNC);
    localparam logic [CW-1:0]    V_START_C = CW'(V_START);
    localparam logic [CW-1:0]    V_END_C   = CW'(V_END);

    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] div_next;
    logic             div_wrap_unused;
    logic [CW-1:0]    h_next;
    logic [CW-1:0]    v_next;
    logic             h_wrap;
    logic             v_wrap_unused;
    logic             v_step;

    // A line ends on the pix_en step that wraps hCount.
    assign v_step = h_wrap;

    mod_counter #(.N(CLK_DIV), .W(DIV_W)) u_div (
        .clk        (clk),
        .rst        (rst),
        .en         (1'b1),
        .count      (div),
        .count_next (div_next),
        .wrap       (div_wrap_unused)
    );

    mod_counter #(.N(H_TOTAL), .W(CW)) u_h (
        .clk        (clk),
        .rst        (rst),
        .en         (pix_en),
        .count      (hCount),
        .count_next (h_next),
        .wrap       (h_wrap)
    );

    mod_counter #(.N(V_TOTAL), .W(CW)) u_v (
        .clk        (clk),
        .rst        (rst),
        .en         (v_step),
        .count      (vCount),
        .count_next (v_next),
        .wrap       (v_wrap_unused)
    );

    // Registered pixel strobe and sync/visible decode from next-state counts.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_en <= 1'b0;
            hSync  <= 1'b0;
            vSync  <= 1'b0;
            bright <= 1'b0;
        end else begin
            pix_en <= (div_next == DIV_LAST);
            hSync  <= (h_next >= H_SYNC_C);
            vSync  <= (v_next >= V_SYNC_C);
            bright <= (h_next >= H_START_C) && (h_next <= H_END_C) &&
                      (v_next >= V_START_C) && (v_next <= V_END_C);
        end
    end

`ifdef VGA_FRAME_TICK_EN
    // One-clock strobe on the edge where vCount leaves the last visible line.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= v_step && (vCount == V_END_C);
        end
    end
`else
    assign frame_tick = 1'b0;
`endif

endmodule
